// File: rtl/sm4_pkg.sv
// Shared types for the SM4 CBC sequencing controller: state encoding,
// 128-bit block type and the default core-done timeout.
package sm4_pkg;

   typedef logic [127:0] blk_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT,
      ST_OUT,
      ST_ERR
   } state_t;

   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/sm4_cbc_ctrl.sv
// CBC chaining controller around an external SM4 block core: one block in
// flight, core handshake by request pulse and done rising edge, sticky timeout.
//
// state | meaning
// IDLE  | no message; waits for start
// LOAD  | in_ready high, waits for an input block
// ISSUE | core_en pulse, timeout timer loaded
// WAIT  | waits for core_done rising edge or timer terminal count
// OUT   | out_valid high until out_ready
// ERR   | core timed out; waits for start
module sm4_cbc_ctrl
   import sm4_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_last,
   output logic         core_en,
   output logic         core_mode,
   output logic [127:0] core_key,
   output logic [127:0] core_intext,
   input  logic [127:0] core_outtext,
   input  logic         core_done,
   output logic         busy,
   output logic         err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t         state, state_nxt;
   blk_t           chain_q, blk_q;
   logic           last_q, done_q, done_rise, err_q;
   logic [TW-1:0]  tmr_q;

   assign done_rise = core_done & ~done_q;
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      core_en   = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            core_en   = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_rise)               state_nxt = ST_OUT;
            else if (tmr_q == TW'(1))    state_nxt = ST_ERR;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = last_q ? ST_IDLE : ST_LOAD;
         end
         ST_ERR:   if (start) state_nxt = ST_LOAD;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Encrypt chains on the ciphertext result; decrypt chains on the captured input.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q     <= '0;
         blk_q       <= '0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         tmr_q       <= '0;
         core_key    <= '0;
         core_mode   <= 1'b0;
         core_intext <= '0;
         out_data    <= '0;
         out_last    <= 1'b0;
      end else begin
         done_q <= core_done;
         case (state)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  chain_q   <= iv;
                  core_key  <= key;
                  core_mode <= mode;
                  err_q     <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  blk_q       <= in_data;
                  last_q      <= in_last;
                  core_intext <= core_mode ? (in_data ^ chain_q) : in_data;
               end
            end
            ST_ISSUE: tmr_q <= TW'(TIMEOUT - 1);
            ST_WAIT: begin
               if (done_rise) begin
                  out_data <= core_mode ? core_outtext : (core_outtext ^ chain_q);
                  out_last <= last_q;
                  chain_q  <= core_mode ? core_outtext : blk_q;
               end else if (tmr_q == TW'(1)) begin
                  err_q <= 1'b1;
               end else begin
                  tmr_q <= tmr_q - TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sm4_cbc_ctrl.sv
// Bench for sm4_cbc_ctrl: behavioural SM4 core stub plus a CBC reference model
// feeding an expected-output queue that one compare process checks each cycle.
module tb_sm4_cbc_ctrl;
   import sm4_pkg::*;

   localparam int CORE_LAT = 3;
   localparam int TMO      = 8;

   localparam blk_t K  = 128'h0123456789abcdeffedcba9876543210;
   localparam blk_t P  = 128'h0123456789abcdeffedcba9876543210;
   localparam blk_t C1 = 128'h681edf34d206965e86b3e94f536e4246;
   localparam blk_t P2 = 128'h693d9a535bad5bb1786f53d7253a7056;
   localparam blk_t IV2 = 128'h00112233445566778899aabbccddeeff;

   localparam logic [7:0] SBOX [0:255] = '{
      8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
      8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
      8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
      8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
      8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
      8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
      8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
      8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
      8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
      8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
      8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
      8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
      8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
      8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
      8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
   };

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] a);
      return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
   endfunction

   function automatic blk_t sm4(input blk_t k_in, input blk_t b_in, input logic enc);
      logic [31:0] k [0:35];
      logic [31:0] x [0:35];
      logic [31:0] rk [0:31];
      logic [31:0] ck, b, r;
      k[0] = k_in[127:96] ^ 32'ha3b1bac6;
      k[1] = k_in[95:64]  ^ 32'h56aa3350;
      k[2] = k_in[63:32]  ^ 32'h677d9197;
      k[3] = k_in[31:0]   ^ 32'hb27022dc;
      for (int i = 0; i < 32; i++) begin
         ck = '0;
         for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'((4 * i + j) * 7)};
         b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
         k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
         rk[i] = k[i+4];
      end
      x[0] = b_in[127:96]; x[1] = b_in[95:64]; x[2] = b_in[63:32]; x[3] = b_in[31:0];
      for (int i = 0; i < 32; i++) begin
         r = enc ? rk[i] : rk[31-i];
         b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ r);
         x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, core_done = 1'b0;
   blk_t key = '0, iv = '0, in_data = '0, core_outtext = '0;
   logic in_ready, out_valid, out_last, core_en, core_mode, busy, err;
   blk_t out_data, core_key, core_intext;

   sm4_cbc_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .iv(iv),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .core_en(core_en), .core_mode(core_mode), .core_key(core_key), .core_intext(core_intext),
      .core_outtext(core_outtext), .core_done(core_done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Core stub: result CORE_LAT cycles after the core_en cycle, or never when dead.
   logic core_dead = 1'b0, spur = 1'b0, c_busy = 1'b0;
   int   c_cnt = 0;
   blk_t c_res = '0;
   always @(posedge clk) begin
      core_done <= spur;
      if (rst) begin
         c_busy <= 1'b0;
         c_cnt  <= 0;
      end else if (core_en && !core_dead) begin
         c_busy <= 1'b1;
         c_cnt  <= CORE_LAT - 1;
         c_res  <= sm4(core_key, core_intext, core_mode);
      end else if (c_busy) begin
         if (c_cnt == 1) begin
            core_done    <= 1'b1;
            core_outtext <= c_res;
            c_busy       <= 1'b0;
         end else begin
            c_cnt <= c_cnt - 1;
         end
      end
   end

   // CBC reference model
   typedef struct packed { blk_t data; logic last; } exp_t;
   exp_t exp_q[$];
   blk_t out_hist[$];
   blk_t m_key = '0, m_chain = '0;
   logic m_mode = 1'b0;

   int   cyc = 0, acc_cyc = 0, n_en = 0;
   logic ov_prev = 1'b0;
   blk_t last_out = '0;
   logic last_out_last = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (in_valid && in_ready) acc_cyc = cyc;
         if (core_en) n_en++;
         if (out_valid) begin
            chk("out_excl", 128'({in_ready, core_en}), 128'(0));
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 128'(out_valid), 128'(0));
            end else begin
               chk("out_data", out_data, exp_q[0].data);
               chk("out_last", 128'(out_last), 128'(exp_q[0].last));
               if (!ov_prev) chk("latency", 128'(cyc - acc_cyc), 128'(2 + CORE_LAT));
               if (out_ready) begin
                  last_out      = out_data;
                  last_out_last = out_last;
                  out_hist.push_back(out_data);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
      ov_prev = out_valid;
   end

   task automatic do_start(input blk_t k, input blk_t v, input logic m);
      @(posedge clk); #1;
      key = k; iv = v; mode = m; start = 1'b1;
      m_key = k; m_chain = v; m_mode = m;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input blk_t d, input logic l);
      exp_t e;
      int n;
      if (m_mode) begin
         e.data = sm4(m_key, d ^ m_chain, 1'b1);
         m_chain = e.data;
      end else begin
         e.data = sm4(m_key, d, 1'b0) ^ m_chain;
         m_chain = d;
      end
      e.last = l;
      exp_q.push_back(e);
      in_valid = 1'b1; in_data = d; in_last = l;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!in_ready && n < 100);
      #1;
      in_valid = 1'b0;
      if (n >= 100) chk("in_ready_timeout", 128'(in_ready), 128'(1));
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 200);
      chk("idle_reached", 128'(busy), 128'(0));
   endtask

   function automatic logic [127:0] all_outs();
      return 128'({in_ready, out_valid, out_last, core_en, core_mode, busy, err}) |
             out_data | core_intext | core_key;
   endfunction

   initial begin
      int n, en_before;
      chk("ref_enc", sm4(K, P, 1'b1), C1);
      chk("ref_dec", sm4(K, C1, 1'b0), P);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", all_outs(), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // single block encrypt / decrypt
      do_start(K, '0, 1'b1);
      send(P, 1'b1);
      wait_idle();
      chk("enc1_data", last_out, C1);
      chk("enc1_last", 128'(last_out_last), 128'(1));

      do_start(K, '0, 1'b0);
      send(C1, 1'b1);
      wait_idle();
      chk("dec1_data", last_out, P);

      // two-block encrypt with spurious done in LOAD and a stray start mid-message
      do_start(K, '0, 1'b1);
      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      repeat (3) @(negedge clk);
      chk("spur_done_ignored", 128'({in_ready, out_valid}), 128'(2'b10));
      send(P, 1'b0);
      @(posedge clk); #1;
      key = ~K; iv = '1; mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key = K;
      send(P2, 1'b1);
      wait_idle();
      chk("enc2_blk0", out_hist[out_hist.size()-2], C1);
      chk("enc2_blk1", last_out, C1);

      do_start(K, '0, 1'b0);
      send(C1, 1'b0);
      send(C1, 1'b1);
      wait_idle();
      chk("dec2_blk0", out_hist[out_hist.size()-2], P);
      chk("dec2_blk1", last_out, P2);

      // output backpressure for 10 cycles
      do_start(K, IV2, 1'b1);
      out_ready = 1'b0;
      send(P2, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      en_before = n_en;
      repeat (10) @(negedge clk);
      chk("bp_no_core_en", 128'(n_en), 128'(en_before));
      chk("bp_hold_valid", 128'({out_valid, in_ready}), 128'(2'b10));
      @(posedge clk); #1 out_ready = 1'b1;
      wait_idle();
      chk("bp_data", last_out, sm4(K, P2 ^ IV2, 1'b1));

      // dead core -> timeout, then restart from ERR
      core_dead = 1'b1;
      do_start(K, '0, 1'b1);
      send(P, 1'b1);
      @(negedge clk);
      chk("to_issue", 128'(core_en), 128'(1));
      n = 0;
      while (!err && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("to_err_delay", 128'(n), 128'(TMO));
      chk("to_err_state", 128'({busy, in_ready, out_valid, core_en}), 128'(4'b1000));
      exp_q.delete();
      core_dead = 1'b0;
      do_start(K, '0, 1'b1);
      @(negedge clk);
      chk("to_restart", 128'({err, in_ready}), 128'(2'b01));
      send(P, 1'b1);
      wait_idle();
      chk("to_recover_data", last_out, C1);

      // reset while waiting on the core
      do_start(K, '0, 1'b1);
      send(P, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_wait_outputs", all_outs(), 128'(0));
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_no_out", 128'(out_valid), 128'(0));
      do_start(K, '0, 1'b1);
      send(P, 1'b1);
      wait_idle();
      chk("rst_rerun_data", last_out, C1);
      chk("rst_rerun_last", 128'(last_out_last), 128'(1));
      chk("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
